downsampler_h_window_fp16: RTL
==============================

DOWNSAMPLER_H_WINDOW_FP16 -- requirements
Module: downsampler_h_window_fp16

Interface
REQ-001 Parameter EXP_WIDTH, default 5, FP16 exponent width.
REQ-002 Parameter FRAC_WIDTH, default 10, FP16 fraction width.
REQ-003 Parameter IMAGE_WIDTH, default 640, input line length in pixels; legal range 1..65535, odd or even.
REQ-004 Parameter FP_WIDTH_REG, default 1+FRAC_WIDTH+EXP_WIDTH, word width.
REQ-005 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst_i  input  1  reset, synchronous, active-high.
REQ-007 Port pixel_i  input  FP_WIDTH_REG  raster pixel, opaque bit pattern.
REQ-008 Port col_i  input  16  column of pixel_i.
REQ-009 Port row_i  input  16  row of pixel_i.
REQ-010 Port valid_i  input  1  pixel_i/col_i/row_i qualifier.
REQ-011 Port window_o  output  FP_WIDTH_REG x [1][2]  stride-2 horizontal window for the downstream 1x2 convolution.
REQ-012 Port col_o  output  16  output (decimated) column.
REQ-013 Port row_o  output  16  output row.
REQ-014 Port valid_o  output  1  window_o/col_o/row_o qualifier, single-cycle pulse per window.
REQ-015 Port drop_o  output  1  one-cycle pulse: an input pixel was discarded.

Function
REQ-016 Block pairs columns (2k, 2k+1) of each row into one window and shall emit exactly one window per pair; no backpressure, no ready.
REQ-017 State machine states: EMPTY (no held pixel), HELD (left pixel, its col and row registered).
REQ-018 EMPTY, valid_i, col_i even, col_i != IMAGE_WIDTH-1: store pixel/col/row, go HELD, no output.
REQ-019 EMPTY, valid_i, col_i even, col_i == IMAGE_WIDTH-1 (odd width tail): emit window {pixel_i, pixel_i} (edge replicate), stay EMPTY.
REQ-020 EMPTY, valid_i, col_i odd: discard pixel, pulse drop_o, stay EMPTY.
REQ-021 HELD, valid_i, col_i == held_col+1 and row_i == held_row: emit window {held, pixel_i}, go EMPTY.
REQ-022 HELD, valid_i, any other col/row: discard held pixel, pulse drop_o, then process the new pixel exactly as in EMPTY (REQ-018..020) the same cycle; if that also drops, drop_o is still a single-cycle 1.
REQ-023 valid_i low: state and held data unchanged, no output; gaps of any length between pixels of a pair are legal.
REQ-024 Window ordering: window_o[0][0] = even-column (left) pixel, window_o[0][1] = odd-column (right) pixel.
REQ-025 col_o = left pixel column >> 1 (logical shift); row_o = left pixel row.
REQ-026 Latency: exactly 1 cycle from the valid_i cycle completing a window to valid_o high; all outputs registered.
REQ-027 When valid_o is low, window_o/col_o/row_o shall hold their last emitted values.
REQ-028 Pixel data shall pass bit-exact (no arithmetic, NaN/Inf/denormal untouched).
REQ-029 col_i >= IMAGE_WIDTH treated as a normal column value by REQ-018..022 (no range check).
REQ-030 Throughput: one pixel accepted every cycle; back-to-back pairs yield valid_o every other cycle.

Reset
REQ-031 rst_i high on a rising edge: state EMPTY, held registers 0, valid_o 0, drop_o 0, window_o 0, col_o 0, row_o 0; takes priority over valid_i that cycle.
REQ-032 Reset while HELD discards the held pixel without pulsing drop_o; first valid pixel after reset is processed from EMPTY.

Verification
REQ-033 IMAGE_WIDTH=4, row 0 cols 0..3 pixels 0x3C00,0x4000,0x4200,0x4400 back-to-back -> valid_o at cycles 2 and 4: {0x3C00,0x4000} col_o 0 row_o 0; {0x4200,0x4400} col_o 1 row_o 0; drop_o never high.
REQ-034 IMAGE_WIDTH=5, row 3 cols 0..4 -> three windows, third = {p4,p4} col_o 2 row_o 3, emitted 1 cycle after col 4.
REQ-035 Col 0 then col 2 (col 1 missing) -> drop_o pulse on cycle after col 2; col 2 held; col 3 then yields window col_o 1.
REQ-036 Col 1 arriving in EMPTY -> drop_o 1 for one cycle, valid_o stays 0; pair col 0/1 with 5 idle cycles between -> one valid window, col_o 0.
REQ-037 Col 0 row 0 held, rst_i 1 cycle, then col 1 row 0 -> all outputs 0 after reset, col 1 dropped (drop_o pulse), no valid_o.
REQ-038 Held col 2 row 0, next pixel col 3 row 1 -> drop_o pulse, no window; pixel 0x7E00 (NaN) pair -> window_o bit-exact 0x7E00.

Source files
------------

// File: rtl/downsampler_h_window_fp16.sv
// Horizontal stride-2 window builder: pairs columns (2k, 2k+1) of a raster
// row into a 1x2 window for a downstream convolution. Pixels are opaque bits.
module downsampler_h_window_fp16 #(
    parameter int unsigned EXP_WIDTH    = 5,
    parameter int unsigned FRAC_WIDTH   = 10,
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] pixel_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic [FP_WIDTH_REG-1:0] window_o [0:0][0:1],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    drop_o
);

    localparam int unsigned COORD_W  = 16;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMAGE_WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [FP_WIDTH_REG-1:0] r_held_pix,  w_held_pix_nxt;
    logic [COORD_W-1:0]      r_held_col,  w_held_col_nxt;
    logic [COORD_W-1:0]      r_held_row,  w_held_row_nxt;
    logic [FP_WIDTH_REG-1:0] r_win_l,     w_win_l_nxt;
    logic [FP_WIDTH_REG-1:0] r_win_r,     w_win_r_nxt;
    logic [COORD_W-1:0]      r_col,       w_col_nxt;
    logic [COORD_W-1:0]      r_row,       w_row_nxt;
    logic                    r_valid,     w_valid_nxt;
    logic                    r_drop,      w_drop_nxt;
    logic                    w_pair;

    // Incoming pixel completes the held left pixel of the same row
    assign w_pair = (r_state == HELD) &&
                    (col_i == r_held_col + COORD_W'(1)) &&
                    (row_i == r_held_row);

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= EMPTY;
            r_held_pix <= '0;
            r_held_col <= '0;
            r_held_row <= '0;
            r_win_l    <= '0;
            r_win_r    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_valid    <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_held_pix <= w_held_pix_nxt;
            r_held_col <= w_held_col_nxt;
            r_held_row <= w_held_row_nxt;
            r_win_l    <= w_win_l_nxt;
            r_win_r    <= w_win_r_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_valid    <= w_valid_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    // Next-state and output decode; a broken pair drops the held pixel and
    // the new pixel is then handled as if arriving in EMPTY
    always_comb begin
        w_state_nxt    = r_state;
        w_held_pix_nxt = r_held_pix;
        w_held_col_nxt = r_held_col;
        w_held_row_nxt = r_held_row;
        w_win_l_nxt    = r_win_l;
        w_win_r_nxt    = r_win_r;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_valid_nxt    = 1'b0;
        w_drop_nxt     = 1'b0;

        if (valid_i) begin
            if (w_pair) begin
                w_win_l_nxt = r_held_pix;
                w_win_r_nxt = pixel_i;
                w_col_nxt   = r_held_col >> 1;
                w_row_nxt   = r_held_row;
                w_valid_nxt = 1'b1;
                w_state_nxt = EMPTY;
            end else begin
                w_drop_nxt  = (r_state == HELD);
                w_state_nxt = EMPTY;
                if (col_i[0]) begin
                    w_drop_nxt = 1'b1;
                end else if (col_i == LAST_COL) begin
                    w_win_l_nxt = pixel_i;
                    w_win_r_nxt = pixel_i;
                    w_col_nxt   = col_i >> 1;
                    w_row_nxt   = row_i;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_held_pix_nxt = pixel_i;
                    w_held_col_nxt = col_i;
                    w_held_row_nxt = row_i;
                    w_state_nxt    = HELD;
                end
            end
        end
    end

    assign window_o[0][0] = r_win_l;
    assign window_o[0][1] = r_win_r;
    assign col_o          = r_col;
    assign row_o          = r_row;
    assign valid_o        = r_valid;
    assign drop_o         = r_drop;

endmodule
